// File: rtl/controller.sv
// ----------------------------------------------------------------------------
// controller
//
// Converts key press/release events into a held-state vector with one bit per
// control. A key event is the rising edge of ready. On each event the key
// named by key_val is set or cleared. Some controls are grouped so that
// pressing one clears the others in its group.
//
// Ports
//    clk           in   1   system clock
//    rst           in   1   synchronous active-high reset
//    ready         in   1   key-event strobe; key_val/press valid while high
//    key_val       in   3   control index 0..7
//    press         in   1   1 = pressed, 0 = released
//    controls_out  out  8   registered held-state vector, 1 = held
//
// controls_out bit map
//    0 speed1   1 speed2   2 speed3   3 back
//    4 forward  5 left     6 right    7 fire
//
// Exclusive groups, where a press clears the other members of its group
//    speed         bits 2..0   one-hot or zero
//    back/forward  bits 4..3
//    left/right    bits 6..5
//    fire          bit  7      stands alone
// ----------------------------------------------------------------------------
module controller (
   input  logic       clk,
   input  logic       rst,
   input  logic       ready,
   input  logic [2:0] key_val,
   input  logic       press,
   output logic [7:0] controls_out
);

   localparam logic [7:0] GRP_SPEED = 8'h07;
   localparam logic [7:0] GRP_FB    = 8'h18;
   localparam logic [7:0] GRP_LR    = 8'h60;
   localparam logic [7:0] GRP_FIRE  = 8'h80;

   logic       ready_q;
   logic       key_event;
   logic [7:0] key_bit;
   logic [7:0] group_mask;
   logic [7:0] controls_next;

   // ready is high for as long as the receiver holds the strobe. Only the
   // first sampled high counts as an event.
   assign key_event = ready & ~ready_q;

   always_comb begin
      key_bit = 8'h00;
      key_bit[key_val] = 1'b1;
   end

   always_comb begin
      group_mask = GRP_FIRE;
      case (key_val)
         3'd0, 3'd1, 3'd2: group_mask = GRP_SPEED;
         3'd3, 3'd4:       group_mask = GRP_FB;
         3'd5, 3'd6:       group_mask = GRP_LR;
         default:          group_mask = GRP_FIRE;
      endcase
   end

   // A press clears the whole group and then sets the chosen bit. Because
   // each group is kept one-hot or zero, pressing a bit that is already held
   // leaves the vector as it was.
   always_comb begin
      controls_next = controls_out;
      if (press) begin
         controls_next = (controls_out & ~group_mask) | key_bit;
      end else begin
         controls_next = controls_out & ~key_bit;
      end
   end

   // Reset is checked first, so an event on the same edge as reset is dropped.
   // Clearing ready_q means ready already high when reset releases is
   // treated as a fresh event.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q      <= 1'b0;
         controls_out <= 8'h00;
      end else begin
         ready_q <= ready;
         if (key_event) begin
            controls_out <= controls_next;
         end
      end
   end

endmodule

// File: tb/tb_controller.sv
// ----------------------------------------------------------------------------
// tb_controller
//
// Directed bench for controller. Every expected value is written out by hand
// as a constant from the control bit map and the group rules.
// ----------------------------------------------------------------------------
module tb_controller;

   logic       clk;
   logic       rst;
   logic       ready;
   logic [2:0] key_val;
   logic       press;
   logic [7:0] controls_out;

   int n_tests;
   int n_fail;

   controller dut (
      .clk          (clk),
      .rst          (rst),
      .ready        (ready),
      .key_val      (key_val),
      .press        (press),
      .controls_out (controls_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle so outputs are read away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete key event: ready high for a single edge, then low for one edge.
   task automatic key_pulse(input logic [2:0] k, input logic p);
      key_val = k;
      press   = p;
      ready   = 1'b1;
      tick();
      ready   = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      ready   = 1'b0;
      key_val = 3'd0;
      press   = 1'b0;

      do_reset();
      check("reset", controls_out, 8'h00);

      // Press forward. The update is visible one edge after ready is first sampled high.
      key_val = 3'd4;
      press   = 1'b1;
      ready   = 1'b1;
      tick();
      check("fwd_latency", controls_out, 8'h10);
      // Holding ready high must not produce more events, even if the key changes.
      for (int i = 0; i < 5; i++) begin
         key_val = 3'd7;
         press   = 1'b1;
         tick();
         check("ready_held", controls_out, 8'h10);
      end
      ready = 1'b0;
      tick();
      check("ready_low", controls_out, 8'h10);

      key_pulse(3'd4, 1'b0);
      check("rel_fwd", controls_out, 8'h00);
      key_pulse(3'd2, 1'b0);
      check("rel_clear_noop", controls_out, 8'h00);

      key_pulse(3'd0, 1'b1);
      check("speed1", controls_out, 8'h01);
      key_pulse(3'd2, 1'b1);
      check("speed3_excl", controls_out, 8'h04);
      key_pulse(3'd4, 1'b1);
      check("forward", controls_out, 8'h14);
      key_pulse(3'd3, 1'b1);
      check("back_excl", controls_out, 8'h0C);
      key_pulse(3'd1, 1'b1);
      check("speed2_excl", controls_out, 8'h0A);

      do_reset();
      check("reset2", controls_out, 8'h00);
      key_pulse(3'd5, 1'b1);
      check("left", controls_out, 8'h20);
      key_pulse(3'd6, 1'b1);
      check("right_excl", controls_out, 8'h40);
      key_pulse(3'd7, 1'b1);
      check("fire", controls_out, 8'hC0);

      // Key inputs change while ready stays low, so no event happens.
      key_val = 3'd6;
      press   = 1'b0;
      tick();
      key_val = 3'd0;
      press   = 1'b1;
      tick();
      check("no_event", controls_out, 8'hC0);

      key_pulse(3'd7, 1'b1);
      check("press_held_noop", controls_out, 8'hC0);
      key_pulse(3'd6, 1'b0);
      check("rel_right", controls_out, 8'h80);
      key_pulse(3'd5, 1'b1);
      check("left_fire", controls_out, 8'hA0);

      // Reset on the same edge as a rising ready: reset wins.
      key_val = 3'd1;
      press   = 1'b1;
      rst     = 1'b1;
      ready   = 1'b1;
      tick();
      check("rst_wins", controls_out, 8'h00);
      // Release reset with ready still high. That edge counts as a new event.
      rst = 1'b0;
      tick();
      check("post_rst_event", controls_out, 8'h02);
      tick();
      check("post_rst_held", controls_out, 8'h02);
      ready = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
